// File: rtl/adc_sample_averager.sv
// Boxcar decimator for the ADC front-end. It sums 2^LOG2_AVG consecutive strobed samples
// and presents their floor-average through a valid/ready register that counts dropped results.
module adc_sample_averager #(
  parameter int DATA_WIDTH = 24,
  parameter int LOG2_AVG   = 4,
  parameter int OVR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_data_frame,
  input  logic                  i_data_ready,
  output logic [DATA_WIDTH-1:0] o_avg_data,
  output logic                  o_avg_valid,
  input  logic                  i_avg_ready,
  output logic [LOG2_AVG:0]     o_sample_cnt,
  output logic [OVR_WIDTH-1:0]  o_overrun_cnt,
  output logic                  o_overrun,
  input  logic                  i_clear_ovr
);

  localparam int ACC_WIDTH = DATA_WIDTH + LOG2_AVG;
  localparam int CNT_WIDTH = LOG2_AVG + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((1 << LOG2_AVG) - 1);
  localparam logic [OVR_WIDTH-1:0] OVR_MAX  = '1;

  logic                         rdy_d;
  logic                         sample_strobe;
  logic                         window_done;
  logic                         load_result;
  logic                         drop_result;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  sample_ext;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [DATA_WIDTH-1:0] result;
  logic [CNT_WIDTH-1:0]         cnt;

  // A level held on i_data_ready contributes exactly one sample.
  assign sample_strobe = i_data_ready & ~rdy_d & i_enable;
  assign window_done   = sample_strobe && (cnt == CNT_LAST);

  // The extra LOG2_AVG accumulator bits absorb the full window, so the sum never wraps.
  assign sample_ext = ACC_WIDTH'(signed'(i_data_frame));
  assign sum        = acc + sample_ext;
  assign result     = DATA_WIDTH'(sum >>> LOG2_AVG);

  // A finished window is kept only if the output register is empty or being emptied now.
  assign load_result = window_done && (!o_avg_valid || i_avg_ready);
  assign drop_result = window_done && o_avg_valid && !i_avg_ready;

  // NOTE: every clocked register below uses non-blocking assignment so that all of them
  // sample the pre-edge values; blocking here would let one block see another's new value.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      rdy_d <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      rdy_d <= i_data_ready;
      if (!i_enable || window_done) begin
        acc <= '0;
        cnt <= '0;
      end else if (sample_strobe) begin
        acc <= sum;
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_avg_data  <= '0;
      o_avg_valid <= 1'b0;
    end else if (load_result) begin
      o_avg_data  <= result;
      o_avg_valid <= 1'b1;
    end else if (o_avg_valid && i_avg_ready) begin
      o_avg_valid <= 1'b0;
    end
  end

  // Clearing wins over a drop landing in the same cycle.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_overrun_cnt <= '0;
      o_overrun     <= 1'b0;
    end else if (i_clear_ovr) begin
      o_overrun_cnt <= '0;
      o_overrun     <= 1'b0;
    end else if (drop_result) begin
      o_overrun <= 1'b1;
      if (o_overrun_cnt != OVR_MAX) begin
        o_overrun_cnt <= o_overrun_cnt + OVR_WIDTH'(1);
      end
    end
  end

  assign o_sample_cnt = cnt;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Self-checking bench for adc_sample_averager at the default 24-bit, 16-sample configuration.
// Expected averages come from exact integer sums floored by division, not from bit shifts.
module tb_adc_sample_averager;

  localparam int DW = 24;
  localparam int L2 = 4;
  localparam int N  = 16;
  localparam int OW = 8;

  logic          clk;
  logic          i_reset;
  logic          i_enable;
  logic [DW-1:0] i_data_frame;
  logic          i_data_ready;
  logic [DW-1:0] o_avg_data;
  logic          o_avg_valid;
  logic          i_avg_ready;
  logic [L2:0]   o_sample_cnt;
  logic [OW-1:0] o_overrun_cnt;
  logic          o_overrun;
  logic          i_clear_ovr;

  int checks = 0;
  int errors = 0;

  adc_sample_averager #(.DATA_WIDTH(DW), .LOG2_AVG(L2), .OVR_WIDTH(OW)) dut (
    .clk           (clk),
    .i_reset       (i_reset),
    .i_enable      (i_enable),
    .i_data_frame  (i_data_frame),
    .i_data_ready  (i_data_ready),
    .o_avg_data    (o_avg_data),
    .o_avg_valid   (o_avg_valid),
    .i_avg_ready   (i_avg_ready),
    .o_sample_cnt  (o_sample_cnt),
    .o_overrun_cnt (o_overrun_cnt),
    .o_overrun     (o_overrun),
    .i_clear_ovr   (i_clear_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Floor of sum / N in plain integer arithmetic.
  function automatic longint floor_avg(input longint s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  task automatic pulse_start(input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    i_data_frame = d;
    i_data_ready = 1'b1;
  endtask

  task automatic pulse(input logic [DW-1:0] d);
    pulse_start(d);
    @(posedge clk);
    #1;
    i_data_ready = 1'b0;
  endtask

  task automatic pulses(input logic [DW-1:0] d, input int n);
    for (int i = 0; i < n; i++) pulse(d);
  endtask

  task automatic drain;
    @(posedge clk);
    #1 i_avg_ready = 1'b1;
    @(posedge clk);
    #1 i_avg_ready = 1'b0;
    checks++;
    if (o_avg_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid: got %b want 0", o_avg_valid);
    end
  endtask

  task automatic test_reset;
    logic [DW+L2+OW+2:0] outs;
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    outs = {o_avg_data, o_avg_valid, o_sample_cnt, o_overrun_cnt, o_overrun};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", outs);
    end
    @(negedge clk) i_reset = 1'b0;
    pulses(24'h000100, 5);
    checks++;
    if (o_sample_cnt !== 5'd5) begin
      errors++;
      $display("FAIL partial_cnt: got %0d want 5", o_sample_cnt);
    end
    // Asynchronous assertion between clock edges.
    @(posedge clk);
    #3 i_reset = 1'b1;
    #1;
    outs = {o_avg_data, o_avg_valid, o_sample_cnt, o_overrun_cnt, o_overrun};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_midwindow: got %h want 0", outs);
    end
    @(negedge clk) i_reset = 1'b0;
    pulses(24'h000010, N);
    checks++;
    if (o_avg_data !== 24'h000010 || o_avg_valid !== 1'b1 || o_overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_recover: got data=%h valid=%b ovr=%0d want 000010/1/0",
               o_avg_data, o_avg_valid, o_overrun_cnt);
    end
    drain();
  endtask

  task automatic test_signed_floor;
    longint s;
    logic [DW-1:0] expv;
    s = 0;
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] d;
      d = (i % 2 == 0) ? 24'hFFFFFF : 24'h000000;
      s += longint'(signed'(d));
      pulse(d);
    end
    expv = DW'(floor_avg(s));
    checks++;
    if (o_avg_data !== expv || o_avg_valid !== 1'b1) begin
      errors++;
      $display("FAIL floor_neg: got %h/%b want %h/1", o_avg_data, o_avg_valid, expv);
    end
    drain();
    pulses(24'h7FFFFF, N);
    checks++;
    if (o_avg_data !== 24'h7FFFFF) begin
      errors++;
      $display("FAIL max_pos: got %h want 7fffff", o_avg_data);
    end
    drain();
  endtask

  task automatic test_level_vs_pulse;
    pulse_start(24'h000055);
    repeat (9) @(posedge clk);
    #1 i_data_ready = 1'b0;
    checks++;
    if (o_sample_cnt !== 5'd1) begin
      errors++;
      $display("FAIL level_once: got %0d want 1", o_sample_cnt);
    end
    // Drop enable for one edge to discard the lone sample.
    @(posedge clk);
    #1 i_enable = 1'b0;
    @(posedge clk);
    #1 i_enable = 1'b1;
    pulses(24'h000020, N - 1);
    pulse_start(24'h000020);
    @(negedge clk);
    checks++;
    if (o_avg_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got valid=%b want 0", o_avg_valid);
    end
    @(posedge clk);
    #1;
    i_data_ready = 1'b0;
    checks++;
    if (o_avg_valid !== 1'b1 || o_avg_data !== 24'h000020) begin
      errors++;
      $display("FAIL latency_result: got %h/%b want 000020/1", o_avg_data, o_avg_valid);
    end
    drain();
  endtask

  task automatic test_back_pressure;
    for (int w = 1; w <= 3; w++) pulses(DW'(w), N);
    checks++;
    if (o_avg_data !== 24'h000001 || o_overrun_cnt !== 8'd2 || o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL backpressure: got data=%h ovr=%0d flag=%b want 000001/2/1",
               o_avg_data, o_overrun_cnt, o_overrun);
    end
    @(posedge clk);
    #1 i_clear_ovr = 1'b1;
    @(posedge clk);
    #1 i_clear_ovr = 1'b0;
    checks++;
    if (o_overrun_cnt !== 8'd0 || o_overrun !== 1'b0 || o_avg_valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_ovr: got cnt=%0d flag=%b valid=%b want 0/0/1",
               o_overrun_cnt, o_overrun, o_avg_valid);
    end
  endtask

  task automatic test_overrun_saturate;
    for (int w = 0; w < 256; w++) pulses(24'h000007, N);
    checks++;
    if (o_overrun_cnt !== 8'hFF || o_overrun !== 1'b1 || o_avg_data !== 24'h000001) begin
      errors++;
      $display("FAIL saturate: got cnt=%0d flag=%b data=%h want 255/1/000001",
               o_overrun_cnt, o_overrun, o_avg_data);
    end
    pulses(24'h000007, N - 1);
    pulse_start(24'h000007);
    i_clear_ovr = 1'b1;
    @(posedge clk);
    #1;
    i_data_ready = 1'b0;
    i_clear_ovr  = 1'b0;
    checks++;
    if (o_overrun_cnt !== 8'd0 || o_overrun !== 1'b0 || o_avg_data !== 24'h000001) begin
      errors++;
      $display("FAIL clear_priority: got cnt=%0d flag=%b data=%h want 0/0/000001",
               o_overrun_cnt, o_overrun, o_avg_data);
    end
    drain();
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] xfer;
    pulses(24'h000005, N);
    checks++;
    if (o_avg_data !== 24'h000005 || o_avg_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_window: got %h/%b want 000005/1", o_avg_data, o_avg_valid);
    end
    pulses(24'h000009, N - 1);
    pulse_start(24'h000009);
    i_avg_ready = 1'b1;
    @(negedge clk);
    xfer = (o_avg_valid && i_avg_ready) ? o_avg_data : 24'hDEAD00;
    checks++;
    if (xfer !== 24'h000005) begin
      errors++;
      $display("FAIL transfer_data: got %h want 000005", xfer);
    end
    @(posedge clk);
    #1;
    i_data_ready = 1'b0;
    i_avg_ready  = 1'b0;
    checks++;
    if (o_avg_data !== 24'h000009 || o_avg_valid !== 1'b1 ||
        o_overrun_cnt !== 8'd0 || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL simultaneous: got data=%h valid=%b ovr=%0d flag=%b want 000009/1/0/0",
               o_avg_data, o_avg_valid, o_overrun_cnt, o_overrun);
    end
    drain();
  endtask

  task automatic test_enable_drop;
    pulses(24'h000100, 7);
    checks++;
    if (o_sample_cnt !== 5'd7) begin
      errors++;
      $display("FAIL pre_drop_cnt: got %0d want 7", o_sample_cnt);
    end
    @(posedge clk);
    #1 i_enable = 1'b0;
    @(posedge clk);
    #1 i_enable = 1'b1;
    checks++;
    if (o_sample_cnt !== 5'd0 || o_avg_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_clears: got cnt=%0d valid=%b want 0/0", o_sample_cnt, o_avg_valid);
    end
    pulses(24'h000004, N - 1);
    checks++;
    if (o_avg_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_result: got valid=%b want 0", o_avg_valid);
    end
    pulse(24'h000004);
    checks++;
    if (o_avg_data !== 24'h000004 || o_avg_valid !== 1'b1) begin
      errors++;
      $display("FAIL enable_window: got %h/%b want 000004/1", o_avg_data, o_avg_valid);
    end
    drain();
  endtask

  task automatic test_random_windows;
    longint s;
    logic [DW-1:0] d;
    logic [DW-1:0] expv;
    i_avg_ready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      s = 0;
      for (int i = 0; i < N; i++) begin
        d = DW'($urandom);
        s += longint'(signed'(d));
        pulse(d);
        if (i < N - 1) begin
          checks++;
          if (o_sample_cnt !== 5'(i + 1)) begin
            errors++;
            $display("FAIL rand_cnt w%0d: got %0d want %0d", w, o_sample_cnt, i + 1);
          end
        end
      end
      expv = DW'(floor_avg(s));
      checks++;
      if (o_avg_data !== expv || o_avg_valid !== 1'b1) begin
        errors++;
        $display("FAIL rand_avg w%0d: got %h/%b want %h/1", w, o_avg_data, o_avg_valid, expv);
      end
    end
    i_avg_ready = 1'b0;
    checks++;
    if (o_overrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rand_overrun: got %0d want 0", o_overrun_cnt);
    end
    drain();
  endtask

  initial begin
    i_reset      = 1'b1;
    i_enable     = 1'b1;
    i_data_frame = '0;
    i_data_ready = 1'b0;
    i_avg_ready  = 1'b0;
    i_clear_ovr  = 1'b0;
    test_reset();
    test_signed_floor();
    test_level_vs_pulse();
    test_back_pressure();
    test_overrun_saturate();
    test_back_to_back();
    test_enable_drop();
    test_random_windows();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
